// File: rtl/wb_router_pkg.sv
// Shared types and helpers for the Wishbone project router.
// The slot field sits in adr[23:20]; the top byte selects the user region.
package wb_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned SLOT_MSB = 23;
  localparam int unsigned SLOT_LSB = 20;

  localparam logic [31:0] ERR_DATA_DFLT = 32'hDEAD_BEEF;

  // A request may be forwarded only to an existing, enabled slot in our region.
  function automatic logic slot_valid(
    input logic [31:0] adr,
    input logic [15:0] active_mask,
    input logic [7:0]  base_hi,
    input logic [4:0]  num_slots
  );
    logic [3:0] slot;
    slot = adr[SLOT_MSB:SLOT_LSB];
    return (adr[31:24] == base_hi) && ({1'b0, slot} < num_slots) && active_mask[slot];
  endfunction

endpackage

// File: rtl/wb_router_timeout.sv
// Wait counter for the REQ phase: cleared on entry, counts while enabled,
// and flags expiry on the last permitted cycle.
module wb_router_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_project_router.sv
// Wishbone classic router from the management port to per-project slaves.
// One transaction in flight; bad slots or silent slaves complete with an error word.
module wb_project_router
  import wb_router_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 16,
  parameter logic [7:0]  BASE_HI   = 8'h30,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = ERR_DATA_DFLT
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  input  logic [NUM_SLOTS-1:0]    active,
  output logic [NUM_SLOTS-1:0]    s_cyc_o,
  output logic [NUM_SLOTS-1:0]    s_stb_o,
  output logic                    s_we_o,
  output logic [3:0]              s_sel_o,
  output logic [31:0]             s_adr_o,
  output logic [31:0]             s_dat_o,
  input  logic [NUM_SLOTS-1:0]    s_ack_i,
  input  logic [32*NUM_SLOTS-1:0] s_dat_i,
  output logic [7:0]              timeout_cnt,
  output logic [3:0]              err_slot
);

  // Handshake: upstream request is cyc&stb; wbs_ack_o is a one-cycle registered
  // pulse issued from RESP. Downstream, cyc/stb of the chosen slot stay high
  // for all of REQ and the slot answers with a one-cycle s_ack_i.
  state_e      state_q, state_d;
  logic [3:0]  slot_q, slot_d;
  logic [3:0]  err_slot_q, err_slot_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] rdat_q, rdat_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic        ack_q, ack_d;
  logic [7:0]  tcnt_q, tcnt_d;

  logic [15:0]          active_ext;
  logic                 req_take;
  logic                 req_valid;
  logic                 tmr_clr;
  logic                 tmr_en;
  logic                 tmr_expire;
  logic                 sel_ack;
  logic [31:0]          sel_dat;
  logic [NUM_SLOTS-1:0] slot_oh;

  always_comb begin
    active_ext = '0;
    active_ext[NUM_SLOTS-1:0] = active;
  end

  // The !ack term keeps the request the master is still holding from being taken twice.
  assign req_take  = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign req_valid = slot_valid(wbs_adr_i, active_ext, BASE_HI, 5'(NUM_SLOTS));
  assign tmr_en    = (state_q == ST_REQ);
  assign tmr_clr   = (state_q == ST_IDLE) & req_take & req_valid;

  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    slot_oh = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (slot_q == 4'(k)) begin
        sel_ack    = s_ack_i[k];
        sel_dat    = s_dat_i[32*k +: 32];
        slot_oh[k] = (state_q == ST_REQ);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    err_slot_d = err_slot_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    rdat_d     = rdat_q;
    we_d       = we_q;
    sel_d      = sel_q;
    tcnt_d     = tcnt_q;
    ack_d      = (state_q == ST_RESP);
    case (state_q)
      ST_IDLE: begin
        if (req_take) begin
          adr_d  = wbs_adr_i;
          wdat_d = wbs_dat_i;
          we_d   = wbs_we_i;
          sel_d  = wbs_sel_i;
          slot_d = wbs_adr_i[SLOT_MSB:SLOT_LSB];
          if (req_valid) begin
            state_d = ST_REQ;
          end else begin
            rdat_d     = ERR_DATA;
            err_slot_d = wbs_adr_i[SLOT_MSB:SLOT_LSB];
            state_d    = ST_RESP;
          end
        end
      end
      ST_REQ: begin
        // Abort outranks everything; a slave ack outranks a coincident expiry.
        if (!wbs_cyc_i) begin
          state_d = ST_IDLE;
        end else if (sel_ack) begin
          rdat_d  = sel_dat;
          state_d = ST_RESP;
        end else if (tmr_expire) begin
          rdat_d     = ERR_DATA;
          err_slot_d = slot_q;
          if (tcnt_q != 8'hFF) begin
            tcnt_d = tcnt_q + 8'd1;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= ST_IDLE;
      slot_q     <= '0;
      err_slot_q <= '0;
      adr_q      <= '0;
      wdat_q     <= '0;
      rdat_q     <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      ack_q      <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      err_slot_q <= err_slot_d;
      adr_q      <= adr_d;
      wdat_q     <= wdat_d;
      rdat_q     <= rdat_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      ack_q      <= ack_d;
      tcnt_q     <= tcnt_d;
    end
  end

  wb_router_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i    (wb_clk_i),
    .rst_ni   (wb_rst_ni),
    .clear_i  (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmr_expire)
  );

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = rdat_q;
  assign s_cyc_o     = slot_oh;
  assign s_stb_o     = slot_oh;
  assign s_we_o      = we_q;
  assign s_sel_o     = sel_q;
  assign s_adr_o     = adr_q;
  assign s_dat_o     = wdat_q;
  assign timeout_cnt = tcnt_q;
  assign err_slot    = err_slot_q;

endmodule

// File: tb/tb_wb_project_router.sv
// Directed plus randomized bench for wb_project_router with a transaction-level
// reference model (expected data, latency, counters) and an expected-data queue.
module tb_wb_project_router;

  localparam int NS = 12;
  localparam int TO = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic            clk;
  logic            rst_n;
  logic            cyc, stb, we;
  logic [3:0]      sel;
  logic [31:0]     adr, wdat;
  logic            wbs_ack_o;
  logic [31:0]     wbs_dat_o;
  logic [NS-1:0]   active;
  logic [NS-1:0]   s_cyc_o, s_stb_o;
  logic            s_we_o;
  logic [3:0]      s_sel_o;
  logic [31:0]     s_adr_o, s_dat_o;
  logic [NS-1:0]   s_ack_i;
  logic [32*NS-1:0] s_dat_i;
  logic [7:0]      timeout_cnt;
  logic [3:0]      err_slot;

  int          total;
  int          bad;
  int          exp_tc;
  logic [3:0]  exp_err;
  logic [31:0] exp_q[$];

  wb_project_router #(
    .NUM_SLOTS (NS),
    .BASE_HI   (8'h30),
    .TIMEOUT   (TO),
    .ERR_DATA  (ERR)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (wdat),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .active      (active),
    .s_cyc_o     (s_cyc_o),
    .s_stb_o     (s_stb_o),
    .s_we_o      (s_we_o),
    .s_sel_o     (s_sel_o),
    .s_adr_o     (s_adr_o),
    .s_dat_o     (s_dat_o),
    .s_ack_i     (s_ack_i),
    .s_dat_i     (s_dat_i),
    .timeout_cnt (timeout_cnt),
    .err_slot    (err_slot)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver + model for one upstream transaction. Called at a negedge.
  // ack_at: the slave acks in its Nth cycle of stb high (<=0 or >TO: never).
  task automatic do_txn(input logic [31:0] a, input logic w, input int ack_at,
                        input logic [31:0] sdat);
    logic [3:0]    slot;
    logic          valid;
    logic [NS-1:0] onehot;
    logic [31:0]   exp_dat;
    int            exp_lat, exp_stb, edges, stbc;
    logic          got, oh_bad;
    logic [31:0]   obs;
    logic [31:0]   wd;
    logic [3:0]    sl;

    slot  = a[23:20];
    valid = 1'b0;
    if (a[31:24] == 8'h30 && int'(slot) < NS) valid = active[slot];
    onehot = valid ? (NS'(1) << slot) : '0;
    if (!valid) begin
      exp_dat = ERR; exp_lat = 2; exp_stb = 0; exp_err = slot;
    end else if (ack_at >= 1 && ack_at <= TO) begin
      exp_dat = sdat; exp_lat = ack_at + 2; exp_stb = ack_at;
    end else begin
      exp_dat = ERR; exp_lat = TO + 2; exp_stb = TO; exp_err = slot;
      if (exp_tc < 255) exp_tc++;
    end
    exp_q.push_back(exp_dat);

    wd = $urandom;
    sl = 4'($urandom_range(0, 15));
    for (int k = 0; k < NS; k++) s_dat_i[32*k +: 32] = $urandom;
    if (int'(slot) < NS) s_dat_i[32*int'(slot) +: 32] = sdat;
    s_ack_i = '0;
    cyc = 1'b1; stb = 1'b1; we = w; sel = sl; adr = a; wdat = wd;

    edges = 0; stbc = 0; got = 1'b0; oh_bad = 1'b0; obs = '0;
    while (!got && edges < 60) begin
      @(negedge clk);
      edges++;
      s_ack_i = NS'($urandom) & ~onehot;
      if (wbs_ack_o) begin
        got = 1'b1;
        obs = wbs_dat_o;
      end else if (s_stb_o != '0 || s_cyc_o != '0) begin
        stbc++;
        if (s_stb_o !== onehot || s_cyc_o !== onehot) oh_bad = 1'b1;
        if (stbc == ack_at) s_ack_i = s_ack_i | onehot;
      end
    end

    check("ack_seen", 32'(got), 32'd1);
    check("latency", 32'(edges), 32'(exp_lat));
    check("rdata", obs, exp_q.pop_front());
    check("stb_cycles", 32'(stbc), 32'(exp_stb));
    check("stb_onehot", 32'(oh_bad), 32'd0);
    check("timeout_cnt", 32'(timeout_cnt), 32'(exp_tc));
    check("err_slot", 32'(err_slot), 32'(exp_err));
    check("s_adr", s_adr_o, a);
    check("s_dat", s_dat_o, wd);
    check("s_we_sel", {27'd0, s_we_o, s_sel_o}, {27'd0, w, sl});

    // Master holds the request through its sampling edge, then releases it.
    @(negedge clk);
    check("ack_single", 32'(wbs_ack_o), 32'd0);
    cyc = 1'b0; stb = 1'b0; s_ack_i = '0;
  endtask

  initial begin
    logic [31:0] ra;
    int          seen_ack;

    total = 0; bad = 0; exp_tc = 0; exp_err = '0;
    rst_n = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
    active = '0; s_ack_i = '0; s_dat_i = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_rdat", wbs_dat_o, 32'd0);
    check("rst_cyc", 32'(s_cyc_o), 32'd0);
    check("rst_stb", 32'(s_stb_o), 32'd0);
    check("rst_adr", s_adr_o, 32'd0);
    check("rst_cnt", {20'd0, timeout_cnt, err_slot}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Read slot 2, slave acks 3 cycles after stb rises
    active = 12'h004;
    do_txn(32'h3020_0010, 1'b0, 4, 32'h1234_5678);
    // Write to inactive slot 5
    do_txn(32'h3050_0000, 1'b1, 1, 32'h5555_5555);
    // Wrong region
    do_txn(32'h2000_0000, 1'b0, 1, 32'h0);
    // Slot index beyond NUM_SLOTS
    active = '1;
    do_txn(32'h30D0_0004, 1'b0, 1, 32'h0);
    // Silent slave: timeout
    active = 12'h006;
    do_txn(32'h3010_0000, 1'b0, 0, 32'h0);
    // Ack coincides with expiry: slave wins
    do_txn(32'h3020_0008, 1'b0, TO, 32'hCAFE_F00D);
    // Same-cycle ack: minimum latency
    do_txn(32'h3020_000C, 1'b1, 1, 32'hA5A5_0001);

    // Randomized transactions
    for (int i = 0; i < 60; i++) begin
      active = NS'($urandom);
      ra = $urandom;
      ra[31:24] = ($urandom_range(0, 7) == 0) ? 8'h20 : 8'h30;
      do_txn(ra, 1'($urandom), $urandom_range(0, 10), $urandom);
    end

    // Timeout counter saturation
    active = 12'h002;
    for (int i = 0; i < 300; i++) begin
      do_txn(32'h3010_0000, 1'b0, 0, 32'h0);
    end
    check("tc_saturated", 32'(timeout_cnt), 32'd255);

    // Abort: master drops cyc during REQ
    active = 12'h008;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3030_0000;
    repeat (3) @(negedge clk);
    check("abort_stb_before", 32'(s_stb_o), 32'h008);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("abort_cyc_dropped", 32'(s_cyc_o), 32'd0);
    seen_ack = 0;
    repeat (12) begin
      @(negedge clk);
      if (wbs_ack_o || s_cyc_o != '0) seen_ack++;
    end
    check("abort_quiet", 32'(seen_ack), 32'd0);
    check("abort_tc", 32'(timeout_cnt), 32'(exp_tc));
    do_txn(32'h3030_0040, 1'b0, 2, 32'h0BAD_F00D);

    // Reset mid-REQ
    active = 12'h002;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3010_0000;
    repeat (3) @(negedge clk);
    check("rreq_stb", 32'(s_stb_o), 32'h002);
    #2 rst_n = 1'b0;
    #1;
    check("rreq_cyc", 32'(s_cyc_o), 32'd0);
    check("rreq_stb0", 32'(s_stb_o), 32'd0);
    check("rreq_ack", 32'(wbs_ack_o), 32'd0);
    check("rreq_rdat", wbs_dat_o, 32'd0);
    check("rreq_adr", s_adr_o, 32'd0);
    check("rreq_cnt", {20'd0, timeout_cnt, err_slot}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    exp_tc = 0; exp_err = '0;
    @(negedge clk);
    rst_n = 1'b1;
    seen_ack = 0;
    repeat (4) begin
      @(negedge clk);
      if (wbs_ack_o) seen_ack++;
    end
    check("rreq_no_ack", 32'(seen_ack), 32'd0);
    do_txn(32'h3010_0020, 1'b0, 3, 32'h7777_1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
